// File: rtl/mul_pkg.sv
// Shared defaults and FSM encoding for the multiplier dot-product accumulator.
package mul_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_VEC_LEN = 4;
    localparam int DEF_MUL_LAT = 2;
    localparam int DEF_ACC_W   = DEF_DATA_W + $clog2(DEF_VEC_LEN);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/mul_vld_dly.sv
// DEPTH-cycle valid delay line with synchronous flush; tail bit is the delayed valid.
module mul_vld_dly #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_flush,
    input  logic i_vld,
    output logic o_vld
);

    logic [DEPTH-1:0] r_sr;

    generate
        if (DEPTH == 1) begin : g_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sr <= '0;
                end else if (i_flush) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= i_vld;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sr <= '0;
                end else if (i_flush) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= {r_sr[DEPTH-2:0], i_vld};
                end
            end
        end
    endgenerate

    assign o_vld = r_sr[DEPTH-1];

endmodule

// File: rtl/mul_acc_dot.sv
// Accumulates VEC_LEN multiplier products into one dot product, gating operand issue
// and presenting the sum on a valid/ready port held stable under backpressure.
module mul_acc_dot
    import mul_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int VEC_LEN = DEF_VEC_LEN,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int ACC_W   = DATA_W + $clog2(VEC_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] mul_out,
    output logic [ACC_W-1:0]  sum_out,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic              busy
);

    localparam int              CNT_W    = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_iss_cnt;
    logic [CNT_W-1:0]  r_prd_cnt;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  r_sum;

    logic              w_accept;
    logic              w_tail;
    logic              w_last_iss;
    logic              w_last_prd;
    logic [ACC_W-1:0]  w_prod_ext;
    logic [ACC_W-1:0]  w_acc_sum;

    assign op_ready   = (r_state == FILL);
    assign w_accept   = op_valid & op_ready;
    assign w_last_iss = w_accept && (r_iss_cnt == LAST_IDX);
    assign w_last_prd = w_tail && (r_prd_cnt == LAST_IDX);
    assign w_prod_ext = ACC_W'(mul_out);
    assign w_acc_sum  = r_acc + w_prod_ext;

    // Tail of this pipe lines up with mul_out carrying the matching product.
    mul_vld_dly #(
        .DEPTH (MUL_LAT)
    ) u_vld_dly (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (clr),
        .i_vld   (w_accept),
        .o_vld   (w_tail)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL:    if (w_last_iss) w_state_nxt = DRAIN;
            DRAIN:   if (w_last_prd) w_state_nxt = DONE;
            DONE:    if (sum_ready)  w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
        if (clr) begin
            w_state_nxt = FILL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss_cnt <= '0;
        end else if (clr) begin
            r_iss_cnt <= '0;
        end else if (w_accept) begin
            r_iss_cnt <= w_last_iss ? '0 : r_iss_cnt + 1'b1;
        end
    end

    // sum_out is deliberately left untouched by clr; only a completion rewrites it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prd_cnt <= '0;
            r_acc     <= '0;
            r_sum     <= '0;
        end else if (clr) begin
            r_prd_cnt <= '0;
            r_acc     <= '0;
        end else if (w_tail) begin
            if (w_last_prd) begin
                r_sum     <= w_acc_sum;
                r_acc     <= '0;
                r_prd_cnt <= '0;
            end else begin
                r_acc     <= (r_prd_cnt == '0) ? w_prod_ext : w_acc_sum;
                r_prd_cnt <= r_prd_cnt + 1'b1;
            end
        end
    end

    assign sum_out   = r_sum;
    assign sum_valid = (r_state == DONE);
    assign busy      = (r_state != FILL) || (r_iss_cnt != '0);

endmodule

// File: tb/tb_mul_acc_dot.sv
// Scoreboard bench for mul_acc_dot with a behavioural 2-cycle multiplier in front.
module tb_mul_acc_dot;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [3:0] mul_a = 4'd0;
    logic [3:0] mul_b = 4'd0;
    logic [7:0] p1 = 8'd0;
    logic [7:0] p2 = 8'd0;
    logic [9:0] sum_out;
    logic       sum_valid;
    logic       sum_ready = 1'b1;
    logic       busy;

    int vec_cnt = 0;
    int miscmp  = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    // Two-stage multiplier model: operands presented in cycle k appear on mul_out in cycle k+2.
    always @(posedge clk) begin
        p1 <= mul_a * mul_b;
        p2 <= p1;
    end

    mul_acc_dot dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .mul_out   (p2),
        .sum_out   (sum_out),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .busy      (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        vec_cnt++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && sum_valid && sum_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sum", int'(sum_out), -1);
            end else begin
                check("sum_out", int'(sum_out), exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [3:0] a, input logic [3:0] b);
        int n = 0;
        op_valid = 1'b1;
        mul_a    = a;
        mul_b    = b;
        while (!op_ready && n < 20) begin
            cyc(1);
            n++;
        end
        if (n >= 20) check("op_ready_timeout", 0, 1);
        cyc(1);
        op_valid = 1'b0;
        mul_a    = 4'd9;
        mul_b    = 4'd9;
    endtask

    task automatic vec4(input logic [3:0] a, input logic [3:0] b);
        repeat (4) issue(a, b);
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (!sum_valid && n < max) begin
            cyc(1);
            n++;
        end
        check("wait_sum_valid", int'(sum_valid), 1);
    endtask

    initial begin
        int seen;

        // Reset state
        cyc(2);
        check("rst_sum_valid", int'(sum_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_op_ready", int'(op_ready), 1);
        check("rst_sum_out", int'(sum_out), 0);
        rst_n = 1'b1;
        cyc(1);

        // Basic: 1+4+9+16 = 30, latency and op_ready timing
        exp_q.push_back(30);
        issue(4'd1, 4'd1);
        issue(4'd2, 4'd2);
        issue(4'd3, 4'd3);
        issue(4'd4, 4'd4);
        check("basic_op_ready_low", int'(op_ready), 0);
        check("basic_busy", int'(busy), 1);
        check("basic_vld_k1", int'(sum_valid), 0);
        cyc(1);
        check("basic_vld_k2", int'(sum_valid), 0);
        cyc(1);
        check("basic_vld_k3", int'(sum_valid), 1);
        cyc(1);
        check("basic_vld_k4", int'(sum_valid), 0);
        check("basic_op_ready_back", int'(op_ready), 1);

        // Max value: 4 * 225 = 900
        exp_q.push_back(900);
        vec4(4'd15, 4'd15);
        wait_valid(10);
        cyc(2);

        // Backpressure: hold 30 for 5 cycles, offered operands ignored
        sum_ready = 1'b0;
        exp_q.push_back(30);
        issue(4'd1, 4'd1);
        issue(4'd2, 4'd2);
        issue(4'd3, 4'd3);
        issue(4'd4, 4'd4);
        wait_valid(10);
        op_valid = 1'b1;
        mul_a    = 4'd7;
        mul_b    = 4'd7;
        for (int i = 0; i < 5; i++) begin
            check("bp_sum_out", int'(sum_out), 30);
            check("bp_op_ready", int'(op_ready), 0);
            check("bp_sum_valid", int'(sum_valid), 1);
            cyc(1);
        end
        op_valid  = 1'b0;
        sum_ready = 1'b1;
        cyc(1);
        check("bp_release_op_ready", int'(op_ready), 1);
        exp_q.push_back(4);
        vec4(4'd1, 4'd1);
        wait_valid(10);
        cyc(2);

        // Gapped input 1,0,1,0,0,1,1: 6+5+16+0 = 27
        exp_q.push_back(27);
        issue(4'd2, 4'd3);
        cyc(1);
        issue(4'd1, 4'd5);
        cyc(2);
        issue(4'd4, 4'd4);
        issue(4'd0, 4'd7);
        wait_valid(10);
        cyc(2);

        // clr after two accepts: in-flight products discarded
        issue(4'd3, 4'd3);
        issue(4'd3, 4'd3);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        check("clr_busy", int'(busy), 0);
        check("clr_op_ready", int'(op_ready), 1);
        check("clr_sum_valid", int'(sum_valid), 0);
        check("clr_sum_out_kept", int'(sum_out), 27);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (sum_valid) seen = 1;
            cyc(1);
        end
        check("clr_no_sum", seen, 0);
        exp_q.push_back(4);
        vec4(4'd1, 4'd1);
        wait_valid(10);
        cyc(2);

        // Asynchronous reset while in DRAIN
        vec4(4'd5, 4'd5);
        check("drain_busy", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sum_valid", int'(sum_valid), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_op_ready", int'(op_ready), 1);
        check("arst_sum_out", int'(sum_out), 0);
        cyc(2);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (sum_valid) seen = 1;
            cyc(1);
        end
        check("arst_no_sum", seen, 0);
        exp_q.push_back(16);
        vec4(4'd2, 4'd2);
        wait_valid(10);
        cyc(2);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) cyc(1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
